// File: rtl/seven_seg_pkg.sv
// Shared constants and the hex-to-segment table for the display scanner.
// Segment order is {a,b,c,d,e,f,g}; every line is active low.
package seven_seg_pkg;

  localparam int MAX_DIGITS = 32;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef logic [MAX_DIGITS-1:0] anode_vec_t;

  localparam anode_vec_t ANODE_OFF = '1;

  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      4'hF: s = 7'b0111000;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex digit to active-low seven-segment pattern.
module hex_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  assign o_seg = hex2seg(i_digit);

endmodule

// File: rtl/seven_segment_scanner.sv
// Multiplexed common-anode seven-segment driver with double-buffered
// digits, leading-zero suppression, per-digit blanking and blink.
module seven_segment_scanner
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD        = 4,
  parameter int BLINK_FRAMES = 128
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    lz_suppress,
  input  logic                    blink_en,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   anode_out,
  output logic                    frame_done
);

  localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam int DW = 4 * NUM_DIGITS;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = ANODE_OFF[NUM_DIGITS-1:0];

  logic [RW-1:0]         r_rcnt;
  logic [IW-1:0]         r_idx;
  logic [BW-1:0]         r_bcnt;
  logic                  r_phase;
  logic [DW-1:0]         r_pend_dig;
  logic [NUM_DIGITS-1:0] r_pend_blank;
  logic                  r_pend_valid;
  logic [DW-1:0]         r_act_dig;
  logic [NUM_DIGITS-1:0] r_act_blank;
  logic [6:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_anode;
  logic                  r_frame_done;

  logic                  w_tick;
  logic                  w_wrap;
  logic                  w_commit;
  logic [RW-1:0]         w_rcnt_nxt;
  logic [IW-1:0]         w_idx_nxt;
  logic [BW-1:0]         w_bcnt_nxt;
  logic                  w_phase_nxt;
  logic [DW-1:0]         w_act_dig_nxt;
  logic [NUM_DIGITS-1:0] w_act_blank_nxt;
  logic [NUM_DIGITS-1:0] w_lz;
  logic                  w_run;
  logic [3:0]            w_dig;
  logic [6:0]            w_seg;
  logic                  w_lit;
  logic [NUM_DIGITS-1:0] w_an_on;

  assign w_tick   = (r_rcnt == RW'(REFRESH_DIV - 1));
  assign w_wrap   = w_tick && (r_idx == IW'(NUM_DIGITS - 1));
  assign w_commit = w_wrap && r_pend_valid;

  // Outputs are built from next-state values so they move with idx.
  assign w_rcnt_nxt      = w_tick ? '0 : r_rcnt + 1'b1;
  assign w_idx_nxt       = w_wrap ? '0 : (w_tick ? r_idx + 1'b1 : r_idx);
  assign w_act_dig_nxt   = w_commit ? r_pend_dig : r_act_dig;
  assign w_act_blank_nxt = w_commit ? r_pend_blank : r_act_blank;

  always_comb begin
    w_bcnt_nxt  = r_bcnt;
    w_phase_nxt = r_phase;
    if (!blink_en) begin
      w_bcnt_nxt  = '0;
      w_phase_nxt = 1'b0;
    end else if (w_wrap) begin
      if (r_bcnt == BW'(BLINK_FRAMES - 1)) begin
        w_bcnt_nxt  = '0;
        w_phase_nxt = ~r_phase;
      end else begin
        w_bcnt_nxt  = r_bcnt + 1'b1;
      end
    end
  end

  // Zero run from the MSB down; digit 0 always stays eligible.
  always_comb begin
    w_lz  = '0;
    w_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      w_run   = w_run & (w_act_dig_nxt[4*i +: 4] == 4'h0);
      w_lz[i] = lz_suppress & w_run;
    end
  end

  assign w_dig   = w_act_dig_nxt[{w_idx_nxt, 2'b00} +: 4];
  assign w_lit   = !(w_act_blank_nxt[w_idx_nxt] | w_lz[w_idx_nxt])
                   && !w_phase_nxt;
  assign w_an_on = AN_OFF ^ (NUM_DIGITS'(1) << w_idx_nxt);

  hex_to_seg u_hex (
    .i_digit (w_dig),
    .o_seg   (w_seg)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rcnt       <= '0;
      r_idx        <= '0;
      r_bcnt       <= '0;
      r_phase      <= 1'b0;
      r_pend_dig   <= '0;
      r_pend_blank <= '1;
      r_pend_valid <= 1'b0;
      r_act_dig    <= '0;
      r_act_blank  <= '1;
      r_seg        <= SEG_OFF;
      r_anode      <= AN_OFF;
      r_frame_done <= 1'b0;
    end else begin
      r_rcnt      <= w_rcnt_nxt;
      r_idx       <= w_idx_nxt;
      r_bcnt      <= w_bcnt_nxt;
      r_phase     <= w_phase_nxt;
      r_act_dig   <= w_act_dig_nxt;
      r_act_blank <= w_act_blank_nxt;
      if (w_commit)
        r_pend_valid <= 1'b0;
      if (load) begin
        r_pend_dig   <= digits_in;
        r_pend_blank <= blank_mask;
        r_pend_valid <= 1'b1;
      end
      r_seg        <= w_lit ? w_seg : SEG_OFF;
      r_anode      <= (w_lit && (w_rcnt_nxt >= RW'(GUARD))) ? w_an_on : AN_OFF;
      r_frame_done <= w_wrap;
    end
  end

  assign seg_out    = r_seg;
  assign anode_out  = r_anode;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Self-checking bench for seven_segment_scanner (4 digits, 8-cycle slots).
// Vector table plus scoreboard, with hand sequences for multi-frame cases.
module tb_seven_segment_scanner;

  localparam logic [6:0] S0  = 7'b0000001;
  localparam logic [6:0] S1  = 7'b1001111;
  localparam logic [6:0] S2  = 7'b0010010;
  localparam logic [6:0] S3  = 7'b0000110;
  localparam logic [6:0] S4  = 7'b1001100;
  localparam logic [6:0] S5  = 7'b0100100;
  localparam logic [6:0] S6  = 7'b0100000;
  localparam logic [6:0] S7  = 7'b0001111;
  localparam logic [6:0] S8  = 7'b0000000;
  localparam logic [6:0] S9  = 7'b0000100;
  localparam logic [6:0] SA  = 7'b0001000;
  localparam logic [6:0] SD  = 7'b1000010;
  localparam logic [6:0] SF  = 7'b0111000;
  localparam logic [6:0] OFF = 7'h7F;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] digits_in;
  logic [3:0]  blank_mask;
  logic        lz_suppress;
  logic        blink_en;
  logic [6:0]  seg_out;
  logic [3:0]  anode_out;
  logic        frame_done;

  seven_segment_scanner #(
    .NUM_DIGITS   (4),
    .REFRESH_DIV  (8),
    .GUARD        (2),
    .BLINK_FRAMES (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .digits_in   (digits_in),
    .blank_mask  (blank_mask),
    .lz_suppress (lz_suppress),
    .blink_en    (blink_en),
    .seg_out     (seg_out),
    .anode_out   (anode_out),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] an;
  } exp_t;

  typedef struct packed {
    logic [15:0] dig;
    logic [3:0]  mask;
    logic        lz;
    logic [27:0] segs;
    logic [15:0] ans;
  } vec_t;

  exp_t sb[$];
  vec_t vt[9];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic wait_fd(input string nm);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      if (frame_done === 1'b1) found = 1'b1;
      else @(negedge clk);
    end
    chk({nm, "_fd_seen"}, {31'd0, found}, 32'd1);
  endtask

  task automatic count_frame(output int lit);
    lit = 0;
    for (int c = 0; c < 32; c++) begin
      if (anode_out !== 4'hF) lit++;
      @(negedge clk);
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] m);
    digits_in  = d;
    blank_mask = m;
    load       = 1'b1;
    @(negedge clk);
    load       = 1'b0;
  endtask

  task automatic pop_chk(input string nm);
    exp_t e;
    if (sb.size() == 0) begin
      chk({nm, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({nm, "_seg"}, {25'd0, seg_out}, {25'd0, e.seg});
      chk({nm, "_an"}, {28'd0, anode_out}, {28'd0, e.an});
    end
  endtask

  // Entered at cycle 0 of a frame; leaves at cycle 0 of the next one.
  task automatic check_slots(input string nm);
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      chk($sformatf("%s_s%0d_guard", nm, s), {28'd0, anode_out}, 32'hF);
      if (s == 0)
        chk({nm, "_fd_pulse"}, {31'd0, frame_done}, 32'd0);
      @(negedge clk);
      pop_chk($sformatf("%s_s%0d", nm, s));
      repeat (6) @(negedge clk);
    end
  endtask

  function automatic vec_t mkv(input logic [15:0] d, input logic [3:0] m,
                               input logic lz, input logic [27:0] sg,
                               input logic [15:0] an);
    vec_t v;
    v.dig  = d;
    v.mask = m;
    v.lz   = lz;
    v.segs = sg;
    v.ans  = an;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int   lit;
    int   bad;
    int   bad2;
    int   exp_lit [6];
    exp_t e;

    reset       = 1'b1;
    load        = 1'b0;
    digits_in   = '0;
    blank_mask  = '0;
    lz_suppress = 1'b0;
    blink_en    = 1'b0;

    vt[0] = mkv(16'h12AF, 4'h0, 1'b0, {S1, S2, SA, SF}, 16'h7BDE);
    vt[1] = mkv(16'h0050, 4'h0, 1'b1, {OFF, OFF, S5, S0}, 16'hFFDE);
    vt[2] = mkv(16'h0000, 4'h0, 1'b1, {OFF, OFF, OFF, S0}, 16'hFFFE);
    vt[3] = mkv(16'h0000, 4'h0, 1'b0, {S0, S0, S0, S0}, 16'h7BDE);
    vt[4] = mkv(16'h3E9C, 4'h5, 1'b0, {S3, OFF, S9, OFF}, 16'h7FDF);
    vt[5] = mkv(16'h0D07, 4'h0, 1'b1, {OFF, SD, S0, S7}, 16'hFBDE);
    vt[6] = mkv(16'h8645, 4'h0, 1'b0, {S8, S6, S4, S5}, 16'h7BDE);
    vt[7] = mkv(16'h0000, 4'hF, 1'b0, {OFF, OFF, OFF, OFF}, 16'hFFFF);
    vt[8] = mkv(16'h0D07, 4'h2, 1'b0, {S0, SD, OFF, S7}, 16'h7BFE);

    repeat (3) @(negedge clk);
    chk("rst_seg", {25'd0, seg_out}, {25'd0, OFF});
    chk("rst_an", {28'd0, anode_out}, 32'hF);
    chk("rst_fd", {31'd0, frame_done}, 32'd0);
    reset = 1'b0;

    wait_fd("boot");
    count_frame(lit);
    chk("boot_dark", lit, 0);
    chk("fd_period", {31'd0, frame_done}, 32'd1);

    for (int i = 0; i < 9; i++) begin
      wait_fd($sformatf("v%0d_pre", i));
      lz_suppress = vt[i].lz;
      for (int s = 0; s < 4; s++) begin
        e.seg = vt[i].segs[s*7 +: 7];
        e.an  = vt[i].ans[s*4 +: 4];
        sb.push_back(e);
      end
      do_load(vt[i].dig, vt[i].mask);
      wait_fd($sformatf("v%0d_commit", i));
      check_slots($sformatf("v%0d", i));
    end

    lz_suppress = 1'b0;
    wait_fd("tear_pre");
    do_load(16'h8645, 4'h0);
    wait_fd("tear_start");
    bad = 0;
    for (int c = 0; c < 32; c++) begin
      if (c == 5) begin
        digits_in = 16'h1111;
        load      = 1'b1;
      end else if (c == 20) begin
        digits_in = 16'h2222;
        load      = 1'b1;
      end else begin
        load      = 1'b0;
      end
      if (anode_out !== 4'hF && (seg_out === S1 || seg_out === S2)) bad++;
      @(negedge clk);
    end
    load = 1'b0;
    chk("tear_old", bad, 0);
    lit  = 0;
    bad2 = 0;
    for (int c = 0; c < 64; c++) begin
      if (anode_out !== 4'hF) begin
        lit++;
        if (seg_out !== S2) bad2++;
      end
      @(negedge clk);
    end
    chk("tear_new", bad2, 0);
    chk("tear_lit", lit, 48);

    exp_lit = '{24, 24, 0, 0, 24, 24};
    blink_en = 1'b1;
    for (int f = 0; f < 6; f++) begin
      count_frame(lit);
      chk($sformatf("blink_f%0d", f), lit, exp_lit[f]);
    end
    repeat (12) @(negedge clk);
    chk("blink_dark", {28'd0, anode_out}, 32'hF);
    blink_en = 1'b0;
    @(negedge clk);
    chk("blink_off_an", {28'd0, anode_out}, 32'hD);
    chk("blink_off_seg", {25'd0, seg_out}, {25'd0, S2});

    wait_fd("sim_pre");
    do_load(16'h8645, 4'h0);
    repeat (30) @(negedge clk);
    e.seg = S5;
    e.an  = 4'hE;
    sb.push_back(e);
    e.seg = S7;
    sb.push_back(e);
    do_load(16'h0D07, 4'h0);
    chk("sim_fd", {31'd0, frame_done}, 32'd1);
    repeat (2) @(negedge clk);
    pop_chk("sim_first");
    wait_fd("sim_next");
    repeat (2) @(negedge clk);
    pop_chk("sim_second");

    do_load(16'h12AF, 4'h0);
    #2 reset = 1'b1;
    #1;
    chk("midrst_an", {28'd0, anode_out}, 32'hF);
    chk("midrst_seg", {25'd0, seg_out}, {25'd0, OFF});
    @(negedge clk);
    reset = 1'b0;
    wait_fd("midrst");
    count_frame(lit);
    chk("midrst_dark0", lit, 0);
    count_frame(lit);
    chk("midrst_dark1", lit, 0);

    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seven_segment_scanner.md
# seven_segment_scanner

Time-multiplexed driver for an N-digit common-anode seven-segment display. It latches a packed set of 4-bit hex digits, scans them one digit at a time at a parametrised refresh rate, and drives shared active-low segment lines plus one-cold active-low anodes. It also provides per-digit blanking, leading-zero suppression, whole-display blink, and tear-free double-buffered updates. It sits between the game score/timer logic and the board display pins.

## Interface
Parameters:
- NUM_DIGITS, 4: number of digits scanned; must be ≥ 2.
- REFRESH_DIV, 100000: clock cycles per digit slot; must be > GUARD.
- GUARD, 4: cycles at the start of each slot with all anodes off (anti-ghosting).
- BLINK_FRAMES, 128: frames per blink half-period; must be ≥ 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- load  in  1  single-cycle strobe that captures digits_in and blank_mask.
- digits_in  in  4*NUM_DIGITS  packed hex digits; [3:0] is digit 0 (least significant, rightmost).
- blank_mask  in  NUM_DIGITS  1 forces that digit dark.
- lz_suppress  in  1  enables leading-zero blanking; sampled live.
- blink_en  in  1  enables whole-display blink; sampled live.
- seg_out  out  7  segments {a,b,c,d,e,f,g}, bit 6 = a, active low.
- anode_out  out  NUM_DIGITS  digit enables, active low, at most one bit low.
- frame_done  out  1  one-cycle pulse at each frame wrap.

## Operation
- **Pending register.** load copies digits_in and blank_mask into a pending register and sets pend_valid. A second load before commit overwrites the pending contents; the last load wins.
- **Active register.** The active register drives the display. It is updated from pending only at a frame boundary, which is the tick where idx wraps from NUM_DIGITS-1 to 0. pend_valid clears at commit.
- **Simultaneous load and frame boundary.** The previous pending value commits, and the new load becomes pending for the next frame.
- **Refresh counter.** rcnt runs 0..REFRESH_DIV-1 and wraps. A tick is rcnt == REFRESH_DIV-1; each tick advances idx (0 → NUM_DIGITS-1 → 0).
- **Anode selection.** anode_out[idx] = 0 when all of the following hold; otherwise all anodes are 1:
  - rcnt ≥ GUARD;
  - the digit is not blanked;
  - the blink phase is not dark.
- **Digit blanking.** A digit is blanked if any of the following hold:
  - active blank_mask[idx] = 1;
  - lz_suppress = 1, idx > 0, and every active digit from NUM_DIGITS-1 down to idx equals 0. Digit 0 is never suppressed by lz_suppress.
- **Segment encoding.** seg_out = HEX2SEG(active digit[idx]) when the digit is lit, else 7'h7F. Encoding is 0→0000001, 1→1001111, 2→0010010, 3→0000110, 4→1001100, 5→0100100, 6→0100000, 7→0001111, 8→0000000, 9→0000100, A→0001000, b→1100000, C→0110001, d→1000010, E→0110000, F→0111000.
- **Blink.** bcnt counts frames. Every BLINK_FRAMES frames, phase toggles and bcnt restarts. When blink_en = 0, phase is held at 0 and bcnt at 0, so blinking always resumes lit. When blink_en = 1 and phase = 1, the display is dark.
- **Register widths.**
  - rcnt: $clog2(REFRESH_DIV) bits.
  - idx: max(1, $clog2(NUM_DIGITS)) bits.
  - bcnt: $clog2(BLINK_FRAMES+1) bits.

## Timing
- **Reset values.** Asynchronous assertion sets:
  - rcnt = 0, idx = 0, bcnt = 0, phase = 0;
  - pending and active digits = 0, pend_valid = 0;
  - active blank_mask = all 1s (display dark until first commit);
  - seg_out = 7'h7F, anode_out = all 1s, frame_done = 0.
- **Reset mid-frame.** Outputs go dark immediately; there is no partial commit.
- **Output registration.** All outputs are registered. seg_out and anode_out reflect the new idx one cycle after the tick, and they change on the same edge.
- **Guard window.** Slot cycles 0..GUARD-1 after each index change have all anodes at 1.
- **frame_done.** Asserted in the cycle after the wrap tick, coincident with the first output cycle of digit 0.
- **Load-to-display latency.** At most NUM_DIGITS*REFRESH_DIV + 1 cycles after load.
- **Live controls.** lz_suppress and blink_en changes take effect one cycle after sampling.

## Structure
- **Package seven_seg_pkg:**
  - HEX2SEG function/constant table;
  - SEG_OFF = 7'h7F;
  - ANODE_OFF helper.
- **Sub-module hex_to_seg:** combinational, 4-bit in, 7-bit out; instanced once on the muxed digit.
- **Top-level logic:**
  - refresh counter;
  - idx;
  - blink counter;
  - pending/active registers;
  - LZ mask generation (a priority scan from the MSB);
  - output registers.

## Test plan
Run with NUM_DIGITS=4, REFRESH_DIV=8, GUARD=2, BLINK_FRAMES=2.
- **Reset state:** assert reset → seg_out = 7'h7F, anode_out = 4'hF; after release, all anodes stay off until the first load commits.
- **Basic scan:** load digits 16'h12AF, blank_mask 0 → after commit:
  - idx0 slot: anode 4'hE, seg 0111000;
  - idx1 slot: anode 4'hD, seg 0001000;
  - idx2 slot: anode 4'hB, seg 0010010;
  - idx3 slot: anode 4'h7, seg 1001111;
  - anodes are all 1 for 2 cycles at each slot start;
  - frame_done pulses every 32 cycles.
- **Tear-free update:** load 16'h1111 mid-frame, then 16'h2222 before the wrap → the display shows the old value until the wrap, then only 2222; 1111 never appears.
- **Leading-zero suppression:** lz_suppress = 1, digits 16'h0050 → idx3 and idx2 dark, idx1 lit (seg 0100100), idx0 lit (seg 0000001). Digits 16'h0000 → only idx0 lit.
- **Blink:** blink_en = 1 → 2 frames lit, then 2 frames all-anodes-off, repeating. Deassert blink_en mid-dark → lit from the next cycle.
- **Simultaneous load and wrap:** load on the wrap tick → the previous pending value commits and the new value commits at the following wrap.
